// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the APB-fed UART transmit FIFO:
//   - drain_state_e   : states of the FIFO-to-transmitter drain FSM
//   - ADDR_*_DEFAULT  : default APB register addresses
//   - STAT_*          : bit positions inside the status register
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } drain_state_e;

  localparam logic [7:0] ADDR_DATA_DEFAULT = 8'h00;
  localparam logic [7:0] ADDR_STAT_DEFAULT = 8'h04;

  // Status register layout: {count[3:0], ovf, full, empty, busy}
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_FULL_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 4;
  localparam int STAT_CNT_MSB   = 7;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// APB3 slave bundle for the UART transmit FIFO.
//   PSEL, PENABLE, PWRITE, PADDR[7:0], PWDATA[7:0] : requester -> block
//   PREADY, PRDATA[7:0], PSLVERR                   : block -> requester
// Handshake: an access completes in the cycle where PSEL & PENABLE are both
// high; PREADY is high in exactly that cycle (no wait states), so every
// access phase is also its completion cycle. PRDATA and PSLVERR are only
// meaningful while PREADY is high.
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic       PREADY;
  logic [7:0] PRDATA;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/uart_fifo_sync.sv
// ---------------------------------------------------------------------------
// uart_fifo_sync
// Single-clock byte FIFO with combinational (show-ahead) read data.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   push_i, wdata_i : write one byte (ignored when full unless popping too)
//   pop_i           : drop the head entry (ignored when empty)
//   rdata_o         : current head entry
//   count_o         : occupancy, 0..DEPTH
//   full_o, empty_o : occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module uart_fifo_sync #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; entries are only observable once written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// APB-writable byte FIFO that feeds a UART transmitter one byte per frame.
//   PCLK, PRESET : clock, synchronous active-low reset
//   apb          : APB slave (uart_tx_fifo_if.slave), zero wait states
//                  ADDR_DATA write -> push byte (PSLVERR if dropped when full)
//                  ADDR_STAT write -> bit0=1 clears sticky overflow
//                  ADDR_STAT read  -> {count[3:0], ovf, full, empty, busy}
//   tx_data      : byte for the transmitter, held from start until next load
//   tx_start     : one-cycle start pulse
//   tx_busy      : transmitter busy while shifting a frame
//   dbg_state_o  : current drain FSM state
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] ADDR_DATA = ADDR_DATA_DEFAULT,
  parameter logic [7:0] ADDR_STAT = ADDR_STAT_DEFAULT
) (
  input  logic          PCLK,
  input  logic          PRESET,
  uart_tx_fifo_if.slave apb,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  output drain_state_e  dbg_state_o
);
  localparam int AW = $clog2(DEPTH);

  drain_state_e state_q, state_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         ovf_q, ovf_d;

  logic         access, wr_data, wr_stat, rd_stat;
  logic         fifo_push, fifo_pop, drop;
  logic [7:0]   fifo_rdata;
  logic [AW:0]  fifo_count;
  logic         fifo_full, fifo_empty;
  logic [7:0]   count_ext;
  logic [7:0]   status;
  logic         busy;

  // ---------------- APB decode ----------------
  assign access  = apb.PSEL & apb.PENABLE;
  assign wr_data = access &  apb.PWRITE & (apb.PADDR == ADDR_DATA);
  assign wr_stat = access &  apb.PWRITE & (apb.PADDR == ADDR_STAT);
  assign rd_stat = access & ~apb.PWRITE & (apb.PADDR == ADDR_STAT);

  // A full FIFO still takes the byte if the drain pops on the same edge.
  assign fifo_push = wr_data & (~fifo_full | fifo_pop);
  assign drop      = wr_data &   fifo_full & ~fifo_pop;

  assign apb.PREADY  = access;
  assign apb.PSLVERR = drop;

  always_comb begin
    count_ext         = '0;
    count_ext[AW:0]   = fifo_count;
  end

  assign busy = (state_q != ST_IDLE) | tx_busy;

  always_comb begin
    status                             = '0;
    status[STAT_CNT_MSB:STAT_CNT_LSB]  = count_ext[3:0];
    status[STAT_OVF_BIT]               = ovf_q;
    status[STAT_FULL_BIT]              = fifo_full;
    status[STAT_EMPTY_BIT]             = fifo_empty;
    status[STAT_BUSY_BIT]              = busy;
  end

  assign apb.PRDATA = rd_stat ? status : 8'h00;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)                         ovf_d = 1'b1;
    else if (wr_stat && apb.PWDATA[0]) ovf_d = 1'b0;
  end

  // ---------------- Storage ----------------
  uart_fifo_sync #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESET),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (apb.PWDATA),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- Drain FSM ----------------
  // WAIT_BUSY waits for the transmitter to acknowledge the start by raising
  // tx_busy; WAIT_DONE waits for the frame to finish.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          fifo_pop  = 1'b1;
          tx_data_d = fifo_rdata;
          state_d   = ST_START;
        end
      end
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q   <= ST_IDLE;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx_start    = (state_q == ST_START);
  assign tx_data     = tx_data_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo
  import uart_pkg::*;
;
  localparam int         DEPTH = 8;
  localparam logic [7:0] A_DATA = 8'h00;
  localparam logic [7:0] A_STAT = 8'h04;

  // ---------------- clock / reset ----------------
  logic PCLK;
  logic PRESET;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy;
  drain_state_e dbg_state;

  uart_tx_fifo_if apb();

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_DATA(A_DATA), .ADDR_STAT(A_STAT)) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .apb         (apb),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .dbg_state_o (dbg_state)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // ---------------- scoreboard / reference model ----------------
  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];     // accepted bytes not yet handed to the transmitter
  logic [7:0] tx_seq[$];    // bytes observed at each start pulse
  logic       ovf_m;
  int         fr_stage;     // 0 no frame, 1 start pulse, 2 awaiting busy, 3 awaiting release
  logic [7:0] last_tx;
  int         busy_left;
  int         busy_min, busy_max;
  logic       model_en, man_busy;
  int         n_starts;

  logic [7:0] s_rd, s_txd;
  logic       s_err, s_rdy, s_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // One clock cycle: drive, check combinational APB outputs, clock, update
  // the reference model and check the transmitter side.
  task automatic cycle(input logic rst_n, input logic sel, input logic en, input logic wr,
                       input logic [7:0] addr, input logic [7:0] wd,
                       output logic [7:0] rd, output logic err, output logic rdy,
                       output logic st, output logic [7:0] txd);
    logic acc, wr_d, busy_pre, pop_exp, full_m, empty_m, err_exp, st_exp;
    logic [7:0] stat_m, rd_exp;
    int occ;
    PRESET      = rst_n;
    apb.PSEL    = sel;
    apb.PENABLE = en;
    apb.PWRITE  = wr;
    apb.PADDR   = addr;
    apb.PWDATA  = wd;
    tx_busy     = man_busy | (model_en && busy_left > 0);
    #1;
    busy_pre = tx_busy;
    acc      = sel & en;
    occ      = exp_q.size();
    full_m   = (occ == DEPTH);
    empty_m  = (occ == 0);
    stat_m   = {4'(occ), ovf_m, full_m, empty_m, (fr_stage != 0) || busy_pre};
    rd_exp   = (acc && !wr && addr == A_STAT) ? stat_m : 8'h00;
    wr_d     = acc && wr && addr == A_DATA;
    pop_exp  = (fr_stage == 0) && (occ > 0) && !busy_pre;
    err_exp  = wr_d && full_m && !pop_exp;
    rd  = apb.PRDATA;
    err = apb.PSLVERR;
    rdy = apb.PREADY;
    chk("pready", rdy, acc);
    chk("prdata", rd, rd_exp);
    chk("pslverr", err, err_exp);
    @(posedge PCLK);
    #1;
    st  = tx_start;
    txd = tx_data;
    st_exp = rst_n && pop_exp;
    if (!rst_n) begin
      exp_q.delete();
      ovf_m = 1'b0; fr_stage = 0; last_tx = 8'h00; busy_left = 0;
    end else begin
      if (pop_exp) begin
        last_tx  = exp_q.pop_front();
        fr_stage = 1;
      end else if (fr_stage == 1) fr_stage = 2;
      else if (fr_stage == 2 && busy_pre)  fr_stage = 3;
      else if (fr_stage == 3 && !busy_pre) fr_stage = 0;
      if (wr_d) begin
        if (err_exp) ovf_m = 1'b1;
        else exp_q.push_back(wd);
      end
      if (acc && wr && addr == A_STAT && wd[0]) ovf_m = 1'b0;
    end
    chk("tx_start", st, st_exp);
    chk("tx_data", txd, last_tx);
    if (busy_left > 0) busy_left--;
    if (st) begin
      n_starts++;
      tx_seq.push_back(txd);
      if (model_en) busy_left = $urandom_range(busy_min, busy_max);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic step(input logic b, input logic sel, input logic en, input logic wr,
                      input logic [7:0] addr, input logic [7:0] wd);
    man_busy = b;
    cycle(1'b1, sel, en, wr, addr, wd, s_rd, s_err, s_rdy, s_st, s_txd);
  endtask

  task automatic do_reset(input logic b);
    man_busy = b;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, s_rd, s_err, s_rdy, s_st, s_txd);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       busy;
    logic       sel, en, wr;
    logic [7:0] addr, wdata;
    logic [7:0] e_rd;
    logic       e_err, e_rdy, e_st;
    logic [7:0] e_txd;
  } vec_t;
  vec_t tbl[$];

  function automatic void row(logic b, logic s, logic e, logic w, logic [7:0] a, logic [7:0] d,
                              logic [7:0] erd, logic eerr, logic erdy, logic est, logic [7:0] etxd);
    vec_t v;
    v.busy = b; v.sel = s; v.en = e; v.wr = w; v.addr = a; v.wdata = d;
    v.e_rd = erd; v.e_err = eerr; v.e_rdy = erdy; v.e_st = est; v.e_txd = etxd;
    tbl.push_back(v);
  endfunction

  initial begin
    ovf_m = 1'b0; fr_stage = 0; last_tx = 8'h00; busy_left = 0;
    busy_min = 1; busy_max = 1; model_en = 1'b0; man_busy = 1'b0; n_starts = 0;

    // write A5 to an idle block: start pulse two cycles after the access
    row(0, 1,1,1, 8'h00, 8'hA5, 8'h00, 0, 1, 0, 8'h00);
    row(0, 0,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hA5);
    row(0, 0,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hA5);
    row(0, 1,1,0, 8'h04, 8'h00, 8'h03, 0, 1, 0, 8'hA5); // empty, FSM waiting for busy
    // transmitter busy: fill with 01..08, 09 is dropped
    for (int i = 1; i <= 8; i++) row(1, 1,1,1, 8'h00, 8'(i), 8'h00, 0, 1, 0, 8'hA5);
    row(1, 1,1,1, 8'h00, 8'h09, 8'h00, 1, 1, 0, 8'hA5);
    row(1, 1,1,0, 8'h04, 8'h00, 8'h8D, 0, 1, 0, 8'hA5); // count=8, ovf, full, busy
    row(1, 1,1,0, 8'h10, 8'h00, 8'h00, 0, 1, 0, 8'hA5);
    row(1, 1,0,0, 8'h04, 8'h00, 8'h00, 0, 0, 0, 8'hA5); // setup phase only
    row(1, 1,1,1, 8'h04, 8'hFE, 8'h00, 0, 1, 0, 8'hA5); // bit0 clear: ovf kept
    row(1, 1,1,0, 8'h04, 8'h00, 8'h8D, 0, 1, 0, 8'hA5);
    row(1, 1,1,1, 8'h04, 8'h01, 8'h00, 0, 1, 0, 8'hA5); // clear ovf
    row(1, 1,1,0, 8'h04, 8'h00, 8'h85, 0, 1, 0, 8'hA5);
    row(1, 1,1,1, 8'h10, 8'h55, 8'h00, 0, 1, 0, 8'hA5); // unmapped write
    row(1, 1,1,0, 8'h04, 8'h00, 8'h85, 0, 1, 0, 8'hA5);

    // reset state
    do_reset(1'b0);
    do_reset(1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_start", tx_start, 1'b0);
    step(0, 1,1,0, A_STAT, 8'h00);
    chk("rst_status", s_rd, 8'h02);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].busy, tbl[i].sel, tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d_prdata", i), s_rd, tbl[i].e_rd);
      chk($sformatf("tbl%0d_pslverr", i), s_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_pready", i), s_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_tx_start", i), s_st, tbl[i].e_st);
      chk($sformatf("tbl%0d_tx_data", i), s_txd, tbl[i].e_txd);
    end

    // drain with a transmitter that stays busy 10 cycles per start
    model_en = 1'b1; busy_min = 10; busy_max = 10; busy_left = 0;
    n_starts = 0; tx_seq.delete();
    repeat (160) step(0, 0,0,0, 8'h00, 8'h00);
    chk("drain_starts", n_starts, 8);
    chk("drain_len", tx_seq.size(), 8);
    for (int i = 0; i < 8 && i < tx_seq.size(); i++)
      chk($sformatf("drain_byte%0d", i), tx_seq[i], i + 1);
    model_en = 1'b0;

    // full FIFO, write lands on the same edge as the pop
    for (int i = 0; i < 8; i++) step(1, 1,1,1, A_DATA, 8'h10 + 8'(i));
    step(0, 1,1,1, A_DATA, 8'h18);
    chk("same_edge_pslverr", s_err, 1'b0);
    chk("same_edge_start", s_st, 1'b1);
    chk("same_edge_txd", s_txd, 8'h10);
    step(1, 1,1,0, A_STAT, 8'h00);
    chk("same_edge_status", s_rd, 8'h85);

    // reset in the middle of a frame with bytes queued
    do_reset(1'b0);
    step(0, 1,1,1, A_DATA, 8'h21);
    step(0, 0,0,0, 8'h00, 8'h00);
    chk("mid_start", s_st, 1'b1);
    chk("mid_txd", s_txd, 8'h21);
    step(1, 1,1,1, A_DATA, 8'h22);
    step(1, 1,1,1, A_DATA, 8'h23);
    step(1, 1,1,1, A_DATA, 8'h24);
    chk("mid_state", dbg_state, ST_WAIT_DONE);
    do_reset(1'b1);
    n_starts = 0;
    step(0, 1,1,0, A_STAT, 8'h00);
    chk("mid_rst_status", s_rd, 8'h02);
    repeat (6) step(0, 0,0,0, 8'h00, 8'h00);
    chk("mid_rst_no_start", n_starts, 0);

    // randomized traffic against the reference model
    model_en = 1'b1; busy_min = 1; busy_max = 20; busy_left = 0;
    for (int i = 0; i < 1200; i++) begin
      int op;
      logic [7:0] oa;
      op = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0: oa = 8'h08;
        1: oa = 8'h10;
        2: oa = 8'hFF;
        default: oa = 8'h01;
      endcase
      man_busy = ($urandom_range(0, 15) == 0);
      if (op < 45)      cycle(1, 1,1,1, A_DATA, 8'($urandom), s_rd, s_err, s_rdy, s_st, s_txd);
      else if (op < 57) cycle(1, 1,1,0, A_STAT, 8'h00, s_rd, s_err, s_rdy, s_st, s_txd);
      else if (op < 62) cycle(1, 1,1,1, A_STAT, 8'($urandom), s_rd, s_err, s_rdy, s_st, s_txd);
      else if (op < 66) cycle(1, 1,1,1, oa, 8'($urandom), s_rd, s_err, s_rdy, s_st, s_txd);
      else if (op < 70) cycle(1, 1,1,0, oa, 8'h00, s_rd, s_err, s_rdy, s_st, s_txd);
      else if (op < 74) cycle(1, 1,0,$urandom_range(0,1), A_STAT, 8'($urandom), s_rd, s_err, s_rdy, s_st, s_txd);
      else if (op < 75) cycle(0, 0,0,0, 8'h00, 8'h00, s_rd, s_err, s_rdy, s_st, s_txd);
      else              cycle(1, 0,0,0, 8'h00, 8'h00, s_rd, s_err, s_rdy, s_st, s_txd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
